fetch_redirect_ctrl: RTL
========================

Name: fetch_redirect_ctrl

Overview:
- Sequencing controller for the instruction-fetch stage. It drives the fetch stage's 2-bit PC-source select and PC write enable, and issues the IF/ID flush.
- Arbitrates simultaneous redirect requests from decode: return, taken branch, jump and call.
- Owns a small return-address stack (RAS) that supplies the 16-bit return address to fetch.
- Sits between the hazard and decode logic and the fetch stage.

Parameters:
- ADDR_W, 16: PC and return-address width.
- RAS_DEPTH, 4: number of RAS entries; must be a power of 2, at least 2.
- SHADOW_CYCLES, 1: cycles after a redirect during which decode requests are ignored; valid range 1..3.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- stall_i  in  1  hazard request: hold the PC this cycle.
- jump_i  in  1  decode has a J-type jump.
- call_i  in  1  decode has a J-type call; implies a jump plus a push.
- branch_taken_i  in  1  decode resolved an I-type branch as taken.
- ret_i  in  1  decode has a return.
- id_npc_i  in  ADDR_W  NPC of the instruction in decode; this is the value pushed on a call.
- pc_src_o  out  2  encoding: 00 sequential, 01 J-type target, 10 I-type target, 11 return address.
- pc_write_o  out  1  PC load enable for the fetch stage.
- flush_o  out  1  squash the instruction being written into IF/ID.
- return_addr_o  out  ADDR_W  current top of the RAS; 0 when the RAS is empty.
- ras_empty_o  out  1  RAS holds no entries.
- ras_full_o  out  1  RAS holds RAS_DEPTH entries.
- ras_underflow_o  out  1  sticky flag: a return was accepted while the RAS was empty.

Behaviour:
- Single clock; synchronous, active-high reset.
- Reset values:
  - state=RUN, shadow counter=0, RAS count=0, RAS pointer=0, all RAS entries=0.
  - ras_underflow_o=0.
  - Combinational outputs settle to pc_src_o=00, pc_write_o=1, flush_o=0, return_addr_o=0, ras_empty_o=1, ras_full_o=0.
- Output timing:
  - pc_src_o, pc_write_o and flush_o are combinational from the current state and inputs.
  - The fetch stage loads the new PC at the next edge, so redirect latency is 1 cycle from request to new PC.
- FSM states: RUN, SHADOW, HALT. HALT exists only with the optional feature.
- RUN, stall_i=1:
  - pc_write_o=0, pc_src_o=00, flush_o=0.
  - All redirect requests are ignored with no push or pop; decode holds its instruction, so the request re-presents.
- RUN, stall_i=0, priority ret_i > branch_taken_i > call_i > jump_i:
  - ret: pc_src=11, pop the RAS.
  - branch: pc_src=10.
  - call: pc_src=01, push id_npc_i.
  - jump: pc_src=01.
  - Every accepted redirect: pc_write_o=1, flush_o=1, next state SHADOW with counter=SHADOW_CYCLES.
  - Lower-priority simultaneous requests are dropped, and a call that loses arbitration does not push.
- RUN, no request: pc_src=00, pc_write=1, flush=0.
- SHADOW:
  - Redirect inputs are ignored.
  - Output is pc_src=00, with pc_write=!stall_i and flush=0.
  - The counter decrements only on non-stalled cycles; at 0 the FSM returns to RUN.
  - stall_i holds the FSM in SHADOW.
- RAS:
  - Circular buffer; return_addr_o = entry[ptr-1].
  - Push: writes entry[ptr], ptr+1, count=min(count+1, RAS_DEPTH).
  - Push when full: overwrites the oldest entry; count stays RAS_DEPTH and ras_full_o stays 1.
  - Pop: ptr-1, count-1. Pop when empty: return_addr_o=0 is used, ptr and count are unchanged, ras_underflow_o is set.
  - Push and pop never occur in the same cycle, because arbitration selects one request.
- ras_underflow_o clears only on reset.
- Reset mid-operation: takes effect at the next edge regardless of state, stall or shadow; the RAS contents are lost.

Optional Feature:
- Macro: FETCH_RAS_UNDERFLOW_HALT_EN.
- Defined:
  - A return accepted with the RAS empty sets ras_underflow_o and moves the FSM to HALT instead of SHADOW.
  - In that redirect cycle, pc_write_o=0 and flush_o=1.
  - In HALT, pc_write_o=0, pc_src_o=00, flush_o=1 every cycle, and all requests are ignored until reset.
- Undefined: an underflow behaves like a normal return to address 0, with SHADOW following; there is no HALT state.

Test Plan:
- Reset then 5 idle cycles -> pc_src_o=00, pc_write_o=1, flush_o=0, ras_empty_o=1, return_addr_o=0 on every cycle.
- Apply call_i with id_npc_i=0x0011, 2 idle cycles, then ret_i -> call cycle: pc_src=01, flush=1; afterwards return_addr_o=0x0011; ret cycle: pc_src=11; ras_empty_o=1 at the next cycle.
- Assert ret_i, branch_taken_i and jump_i together with the RAS holding 0x0020 -> pc_src=11, one pop only; the next cycle is SHADOW with pc_src=00 and flush=0.
- Assert stall_i=1 with jump_i=1 for 3 cycles, then stall_i=0 -> pc_write=0 and flush=0 while stalled, no state change; redirect pc_src=01, flush=1 in the first unstalled cycle.
- Push 5 calls with NPC 1..5 at RAS_DEPTH=4 -> ras_full_o=1; pops return 5, 4, 3, 2; the 5th pop sets ras_underflow_o and uses return_addr_o=0 (with the macro defined: HALT, pc_write=0 until reset).
- Apply reset while in SHADOW after a call -> next cycle: state RUN, ras_empty_o=1, ras_underflow_o=0, pc_write_o=1.

Source files
------------

// File: rtl/fetch_redirect_ctrl.sv
`default_nettype none
// ----------------------------------------------------------------------------
// fetch_redirect_ctrl : fetch PC-source sequencing, redirect arbitration, RAS
// Optional macro FETCH_RAS_UNDERFLOW_HALT_EN : halt fetch on RAS underflow
// Revision: 1.0
// ----------------------------------------------------------------------------
module fetch_redirect_ctrl #(
  parameter int ADDR_W        = 16,
  parameter int RAS_DEPTH     = 4,
  parameter int SHADOW_CYCLES = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              stall_i,
  input  logic              jump_i,
  input  logic              call_i,
  input  logic              branch_taken_i,
  input  logic              ret_i,
  input  logic [ADDR_W-1:0] id_npc_i,
  output logic [1:0]        pc_src_o,
  output logic              pc_write_o,
  output logic              flush_o,
  output logic [ADDR_W-1:0] return_addr_o,
  output logic              ras_empty_o,
  output logic              ras_full_o,
  output logic              ras_underflow_o
);

  localparam int PTR_W = $clog2(RAS_DEPTH);
  localparam int CNT_W = $clog2(RAS_DEPTH + 1);
  localparam logic [CNT_W-1:0] FULL_CNT    = CNT_W'(RAS_DEPTH);
  localparam logic [1:0]       SHADOW_INIT = 2'(SHADOW_CYCLES);

  localparam logic [1:0] PC_SEQ = 2'b00;
  localparam logic [1:0] PC_J   = 2'b01;
  localparam logic [1:0] PC_I   = 2'b10;
  localparam logic [1:0] PC_RET = 2'b11;

`ifdef FETCH_RAS_UNDERFLOW_HALT_EN
  typedef enum logic [1:0] {RUN = 2'd0, SHADOW = 2'd1, HALT = 2'd2} state_t;
`else
  typedef enum logic [1:0] {RUN = 2'd0, SHADOW = 2'd1} state_t;
`endif

  state_t            state;
  state_t            state_nxt;
  logic [1:0]        shadow_cnt;
  logic [1:0]        shadow_cnt_nxt;
  logic              push;
  logic              pop;
  logic              any_req;

  logic [ADDR_W-1:0] ras_mem [RAS_DEPTH];
  logic [PTR_W-1:0]  ras_ptr;
  logic [PTR_W-1:0]  top_idx;
  logic [CNT_W-1:0]  ras_cnt;
  logic              underflow;

  assign any_req = ret_i | branch_taken_i | call_i | jump_i;
  assign top_idx = ras_ptr - 1'b1;

  assign ras_empty_o     = (ras_cnt == '0);
  assign ras_full_o      = (ras_cnt == FULL_CNT);
  assign return_addr_o   = ras_empty_o ? '0 : ras_mem[top_idx];
  assign ras_underflow_o = underflow;

  always_comb begin
    state_nxt      = state;
    shadow_cnt_nxt = shadow_cnt;
    pc_src_o       = PC_SEQ;
    pc_write_o     = 1'b1;
    flush_o        = 1'b0;
    push           = 1'b0;
    pop            = 1'b0;
    case (state)
      RUN: begin
        if (stall_i) begin
          pc_write_o = 1'b0;
        end else if (any_req) begin
          flush_o        = 1'b1;
          state_nxt      = SHADOW;
          shadow_cnt_nxt = SHADOW_INIT;
          if (ret_i) begin
            pc_src_o = PC_RET;
            pop      = 1'b1;
`ifdef FETCH_RAS_UNDERFLOW_HALT_EN
            if (ras_empty_o) begin
              pc_write_o = 1'b0;
              state_nxt  = HALT;
            end
`endif
          end else if (branch_taken_i) begin
            pc_src_o = PC_I;
          end else if (call_i) begin
            pc_src_o = PC_J;
            push     = 1'b1;
          end else begin
            pc_src_o = PC_J;
          end
        end
      end
      SHADOW: begin
        pc_write_o = !stall_i;
        // Count only cycles in which fetch actually advanced past the redirect.
        if (!stall_i) begin
          if (shadow_cnt <= 2'd1) begin
            shadow_cnt_nxt = 2'd0;
            state_nxt      = RUN;
          end else begin
            shadow_cnt_nxt = shadow_cnt - 2'd1;
          end
        end
      end
`ifdef FETCH_RAS_UNDERFLOW_HALT_EN
      HALT: begin
        pc_write_o = 1'b0;
        flush_o    = 1'b1;
      end
`endif
      default: begin
        state_nxt      = RUN;
        shadow_cnt_nxt = 2'd0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= RUN;
      shadow_cnt <= 2'd0;
    end else begin
      state      <= state_nxt;
      shadow_cnt <= shadow_cnt_nxt;
    end
  end

  // A push on a full stack wraps the pointer and silently drops the oldest entry.
  always_ff @(posedge clk) begin
    if (reset) begin
      ras_ptr   <= '0;
      ras_cnt   <= '0;
      underflow <= 1'b0;
    end else if (push) begin
      ras_ptr <= ras_ptr + 1'b1;
      if (ras_cnt != FULL_CNT) begin
        ras_cnt <= ras_cnt + 1'b1;
      end
    end else if (pop) begin
      if (ras_cnt != '0) begin
        ras_ptr <= ras_ptr - 1'b1;
        ras_cnt <= ras_cnt - 1'b1;
      end else begin
        underflow <= 1'b1;
      end
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < RAS_DEPTH; gi++) begin : g_ras_entry
      always_ff @(posedge clk) begin
        if (reset) begin
          ras_mem[gi] <= '0;
        end else if (push && (ras_ptr == PTR_W'(gi))) begin
          ras_mem[gi] <= id_npc_i;
        end
      end
    end
  endgenerate

endmodule
`default_nettype wire
